// File: rtl/rom_dwnld_mapper_if.sv
// Loader-to-SDRAM programming bus: byte-serial ioctl download in, 16-bit masked prog writes out.
interface rom_dwnld_mapper_if;
    logic        downloading;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wr;
    logic        sdram_ack;
    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic        prog_we;
    logic        prom_we;
    logic        header;

    modport master (
        output downloading, ioctl_addr, ioctl_dout, ioctl_wr, sdram_ack,
        input  prog_addr, prog_data, prog_mask, prog_we, prom_we, header
    );

    modport slave (
        input  downloading, ioctl_addr, ioctl_dout, ioctl_wr, sdram_ack,
        output prog_addr, prog_data, prog_mask, prog_we, prom_we, header
    );
endinterface

// File: rtl/rom_dwnld_mapper.sv
// Maps the byte-serial ROM download onto SDRAM programming writes, with header skip,
// optional byte-lane swap and a separately strobed PROM region.
module rom_dwnld_mapper #(
    parameter bit          SWAB       = 1'b0,
    parameter logic [24:0] HEADER     = 25'd0,
    parameter logic [24:0] PROM_START = 25'h1FF_FFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    rom_dwnld_mapper_if.slave bus
);

    logic [24:0] pay_addr;
    logic [24:0] prom_off;
    logic        is_hdr;
    logic        is_prom;
    logic        wr_ok;

    logic [21:0] prog_addr_q;
    logic [7:0]  prog_data_q;
    logic [1:0]  prog_mask_q;
    logic        prog_we_q;
    logic        prom_we_q;
    logic        header_q;

    assign pay_addr = bus.ioctl_addr - HEADER;
    assign prom_off = pay_addr - PROM_START;
    assign is_prom  = pay_addr >= PROM_START;
    assign wr_ok    = bus.ioctl_wr & bus.downloading;

    // With no header the compare would be constant; tie it off instead.
    generate
        if (HEADER == 25'd0) begin : g_no_hdr
            assign is_hdr = 1'b0;
        end else begin : g_hdr
            assign is_hdr = bus.ioctl_addr < HEADER;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prog_addr_q <= '0;
            prog_data_q <= '0;
            prog_mask_q <= 2'b11;
            prog_we_q   <= 1'b0;
            prom_we_q   <= 1'b0;
            header_q    <= 1'b0;
        end else begin
            prom_we_q <= 1'b0;
            header_q  <= 1'b0;
            if (!bus.downloading) begin
                prog_we_q   <= 1'b0;
                prog_mask_q <= 2'b11;
            end else begin
                if (bus.sdram_ack)
                    prog_we_q <= 1'b0;
                // A new ROM byte overrides a same-cycle acknowledge.
                if (wr_ok) begin
                    if (is_hdr) begin
                        header_q <= 1'b1;
                    end else if (is_prom) begin
                        prog_addr_q <= prom_off[21:0];
                        prog_data_q <= bus.ioctl_dout;
                        prog_mask_q <= 2'b11;
                        prom_we_q   <= 1'b1;
                    end else begin
                        prog_addr_q <= pay_addr[22:1];
                        prog_data_q <= bus.ioctl_dout;
                        prog_mask_q <= (pay_addr[0] ^ SWAB) ? 2'b01 : 2'b10;
                        prog_we_q   <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.prog_addr = prog_addr_q;
    assign bus.prog_data = prog_data_q;
    assign bus.prog_mask = prog_mask_q;
    assign bus.prog_we   = prog_we_q;
    assign bus.prom_we   = prom_we_q;
    assign bus.header    = header_q;

endmodule

// File: tb/tb_rom_dwnld_mapper.sv
// Bench for rom_dwnld_mapper: four parameterisations share one download stream,
// expected writes are queued per byte and popped when the registered outputs appear.
module tb_rom_dwnld_mapper;

    typedef struct {
        int          dut;
        int          kind;   // 0 header, 1 rom, 2 prom
        logic [21:0] addr;
        logic [7:0]  data;
        logic [1:0]  mask;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dl = 1'b0;
    logic [24:0] ad = '0;
    logic [7:0]  dt = '0;
    logic        wr = 1'b0;
    logic        ack = 1'b0;

    int checks = 0;
    int failures = 0;

    bit          swab_c [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [24:0] hdr_c  [4] = '{25'd0, 25'd0, 25'h10, 25'd0};
    logic [24:0] ps_c   [4] = '{25'h1FF_FFFF, 25'h1FF_FFFF, 25'h1FF_FFFF, 25'h1000};

    logic [21:0] last_addr [4];
    logic [7:0]  last_data [4];
    bit          exp_pend  [4];
    exp_t        sb [$];

    logic [21:0] o_addr [4];
    logic [7:0]  o_data [4];
    logic [1:0]  o_mask [4];
    logic        o_pwe  [4];
    logic        o_rwe  [4];
    logic        o_hdr  [4];

    rom_dwnld_mapper_if if0 ();
    rom_dwnld_mapper_if if1 ();
    rom_dwnld_mapper_if if2 ();
    rom_dwnld_mapper_if if3 ();

    rom_dwnld_mapper u_a (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    rom_dwnld_mapper #(.SWAB(1'b1)) u_b (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    rom_dwnld_mapper #(.HEADER(25'h10)) u_c (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
    rom_dwnld_mapper #(.PROM_START(25'h1000)) u_d (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

    always #5 clk = ~clk;

    assign if0.downloading = dl; assign if0.ioctl_addr = ad; assign if0.ioctl_dout = dt;
    assign if0.ioctl_wr = wr;    assign if0.sdram_ack = ack;
    assign if1.downloading = dl; assign if1.ioctl_addr = ad; assign if1.ioctl_dout = dt;
    assign if1.ioctl_wr = wr;    assign if1.sdram_ack = ack;
    assign if2.downloading = dl; assign if2.ioctl_addr = ad; assign if2.ioctl_dout = dt;
    assign if2.ioctl_wr = wr;    assign if2.sdram_ack = ack;
    assign if3.downloading = dl; assign if3.ioctl_addr = ad; assign if3.ioctl_dout = dt;
    assign if3.ioctl_wr = wr;    assign if3.sdram_ack = ack;

    assign o_addr[0] = if0.prog_addr; assign o_addr[1] = if1.prog_addr;
    assign o_addr[2] = if2.prog_addr; assign o_addr[3] = if3.prog_addr;
    assign o_data[0] = if0.prog_data; assign o_data[1] = if1.prog_data;
    assign o_data[2] = if2.prog_data; assign o_data[3] = if3.prog_data;
    assign o_mask[0] = if0.prog_mask; assign o_mask[1] = if1.prog_mask;
    assign o_mask[2] = if2.prog_mask; assign o_mask[3] = if3.prog_mask;
    assign o_pwe[0]  = if0.prog_we;   assign o_pwe[1]  = if1.prog_we;
    assign o_pwe[2]  = if2.prog_we;   assign o_pwe[3]  = if3.prog_we;
    assign o_rwe[0]  = if0.prom_we;   assign o_rwe[1]  = if1.prom_we;
    assign o_rwe[2]  = if2.prom_we;   assign o_rwe[3]  = if3.prom_we;
    assign o_hdr[0]  = if0.header;    assign o_hdr[1]  = if1.header;
    assign o_hdr[2]  = if2.header;    assign o_hdr[3]  = if3.header;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int d, input logic [24:0] addr, input logic [7:0] dout);
        exp_t e;
        logic [24:0] a;
        logic [24:0] off;
        a = addr - hdr_c[d];
        off = a - ps_c[d];
        e.dut = d;
        if (addr < hdr_c[d]) begin
            e.kind = 0; e.addr = last_addr[d]; e.data = last_data[d]; e.mask = 2'b11;
        end else if (a < ps_c[d]) begin
            e.kind = 1; e.addr = a[22:1]; e.data = dout;
            e.mask = (a[0] ^ swab_c[d]) ? 2'b01 : 2'b10;
        end else begin
            e.kind = 2; e.addr = off[21:0]; e.data = dout; e.mask = 2'b11;
        end
        return e;
    endfunction

    task automatic check_idle_all(input string tag);
        for (int d = 0; d < 4; d++) begin
            check_val($sformatf("%s_prog_we%0d", tag, d), {31'd0, o_pwe[d]}, 32'd0);
            check_val($sformatf("%s_prom_we%0d", tag, d), {31'd0, o_rwe[d]}, 32'd0);
            check_val($sformatf("%s_header%0d", tag, d), {31'd0, o_hdr[d]}, 32'd0);
        end
    endtask

    // Drive one ioctl byte (optionally with an ack in the same cycle), then score it.
    task automatic send(input logic [24:0] a, input logic [7:0] b, input logic with_ack);
        exp_t e;
        for (int d = 0; d < 4; d++) begin
            e = model(d, a, b);
            sb.push_back(e);
            exp_pend[d] = (exp_pend[d] && !with_ack) || (e.kind == 1);
            if (e.kind != 0) begin
                last_addr[d] = e.addr;
                last_data[d] = e.data;
            end
        end
        ad = a; dt = b; wr = 1'b1; ack = with_ack;
        @(negedge clk);
        wr = 1'b0; ack = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_val($sformatf("a%0h_d%0d_prog_we", a, e.dut), {31'd0, o_pwe[e.dut]}, {31'd0, exp_pend[e.dut]});
            check_val($sformatf("a%0h_d%0d_prom_we", a, e.dut), {31'd0, o_rwe[e.dut]}, {31'd0, e.kind == 2});
            check_val($sformatf("a%0h_d%0d_header", a, e.dut), {31'd0, o_hdr[e.dut]}, {31'd0, e.kind == 0});
            check_val($sformatf("a%0h_d%0d_addr", a, e.dut), {10'd0, o_addr[e.dut]}, {10'd0, e.addr});
            check_val($sformatf("a%0h_d%0d_data", a, e.dut), {24'd0, o_data[e.dut]}, {24'd0, e.data});
            if (e.kind != 0)
                check_val($sformatf("a%0h_d%0d_mask", a, e.dut), {30'd0, o_mask[e.dut]}, {30'd0, e.mask});
        end
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            check_val($sformatf("a%0h_d%0d_strobe_clr", a, d), {30'd0, o_rwe[d], o_hdr[d]}, 32'd0);
            check_val($sformatf("a%0h_d%0d_we_hold", a, d), {31'd0, o_pwe[d]}, {31'd0, exp_pend[d]});
        end
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        for (int d = 0; d < 4; d++) begin
            exp_pend[d] = 1'b0;
            check_val($sformatf("ack_clr_d%0d", d), {31'd0, o_pwe[d]}, 32'd0);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 4; d++) begin
            last_addr[d] = '0; last_data[d] = '0; exp_pend[d] = 1'b0;
        end
    endtask

    initial begin
        clear_model();
        // Reset with a live write strobe present.
        rst_n = 1'b0; dl = 1'b1; wr = 1'b1; ad = 25'h10; dt = 8'hA5;
        repeat (2) @(negedge clk);
        check_idle_all("rst");
        check_val("rst_mask", {30'd0, o_mask[0]}, 32'd3);
        check_val("rst_addr", {10'd0, o_addr[0]}, 32'd0);
        wr = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_all("post_rst");
        check_val("post_rst_mask", {30'd0, o_mask[3]}, 32'd3);

        // Test-plan byte; hold ack off, then acknowledge.
        send(25'h10, 8'hA5, 1'b0);
        check_val("plan_addr_a", {10'd0, o_addr[0]}, 32'h08);
        check_val("plan_mask_a", {30'd0, o_mask[0]}, 32'h2);
        repeat (4) begin
            @(negedge clk);
            check_val("hold_we_a", {31'd0, o_pwe[0]}, 32'd1);
        end
        ack_pulse();

        send(25'h11, 8'h5A, 1'b0); ack_pulse();
        send(25'h05, 8'h11, 1'b0); ack_pulse();
        send(25'h12, 8'h22, 1'b0);
        check_val("plan_addr_c", {10'd0, o_addr[2]}, 32'h01);
        // PROM byte while a ROM write is still pending on every instance.
        send(25'h1003, 8'h3C, 1'b0);
        check_val("plan_prom_addr_d", {10'd0, o_addr[3]}, 32'h003);
        ack_pulse();
        send(25'h0FFF, 8'h77, 1'b0); ack_pulse();
        send(25'h1000, 8'h88, 1'b0); ack_pulse();
        send(25'h1FF_F003, 8'h99, 1'b0); ack_pulse();
        send(25'h0F, 8'h44, 1'b0); ack_pulse();
        for (int i = 0; i < 4; i++) begin
            send(25'(($urandom_range(0, 25'h1FFF))), 8'($urandom), 1'b0);
            ack_pulse();
        end

        // Write and ack in the same cycle: the new write wins.
        send(25'h30, 8'hC1, 1'b0);
        send(25'h40, 8'hC2, 1'b1);
        check_val("same_cyc_addr_a", {10'd0, o_addr[0]}, 32'h20);
        ack_pulse();

        // Strobes while not downloading are ignored.
        dl = 1'b0;
        @(negedge clk);
        ad = 25'h1003; wr = 1'b1;
        @(negedge clk);
        ad = 25'h05;
        @(negedge clk);
        wr = 1'b0;
        check_idle_all("no_dl");
        dl = 1'b1;
        @(negedge clk);

        // Downloading falls with a write pending.
        send(25'h50, 8'hD1, 1'b0);
        dl = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            check_val($sformatf("dl_fall_we_d%0d", d), {31'd0, o_pwe[d]}, 32'd0);
            check_val($sformatf("dl_fall_mask_d%0d", d), {30'd0, o_mask[d]}, 32'd3);
            exp_pend[d] = 1'b0;
        end
        dl = 1'b1;
        @(negedge clk);

        // Asynchronous reset mid-operation drops the pending write at once.
        send(25'h60, 8'hE1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_idle_all("mid_rst");
        check_val("mid_rst_mask", {30'd0, o_mask[0]}, 32'd3);
        check_val("mid_rst_addr", {10'd0, o_addr[0]}, 32'd0);
        check_val("mid_rst_data", {24'd0, o_data[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_model();
        @(negedge clk);
        send(25'h13, 8'hF0, 1'b0);
        ack_pulse();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
